// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control FSM: opcodes, states,
// ALU operations and datapath select codes.
package mc_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI
    } state_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the control FSM and the memory.
interface multicycle_ctrl_if;
    logic MemReq;
    logic AdrSrc;
    logic MemWrite;
    logic MemReady;

    modport master (output MemReq, AdrSrc, MemWrite, input MemReady);
    modport slave  (input MemReq, AdrSrc, MemWrite, output MemReady);
endinterface

// File: rtl/alu_decoder.sv
// funct3/funct7 to ALU operation; the alternate (sub) encoding on funct3=000
// applies only to R-type, shifts honour funct7 for both forms.
module alu_decoder
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_rtype,
    output logic [3:0] alu_control
);
    logic alt;
    assign alt = (funct7 == F7_ALT);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            3'b000:  alu_control = (is_rtype && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_control = ALU_SLL;
            3'b010:  alu_control = ALU_SLT;
            3'b011:  alu_control = ALU_SLTU;
            3'b100:  alu_control = ALU_XOR;
            3'b101:  alu_control = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_control = ALU_OR;
            default: alu_control = ALU_AND;
        endcase
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I datapath.
// Define MC_PERF_CNT_EN to build the cycle / retired-instruction counters.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            op,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic                  Zero,
    multicycle_ctrl_if.master     mem,
    output logic                  IRWrite,
    output logic                  PCWrite,
    output logic                  RegWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [3:0]            ALUControl,
    output logic [2:0]            ImmSrc,
    output logic                  IllegalOp,
    output logic [DATA_WIDTH-1:0] CycleCnt,
    output logic [DATA_WIDTH-1:0] InstRet
);
    state_e     state_q, state_d;
    logic       mem_req, adr_src, mem_write;
    logic [3:0] dec_alu;

    alu_decoder u_alu_dec (
        .funct3      (funct3),
        .funct7      (funct7),
        .is_rtype    (state_q == S_EXECR),
        .alu_control (dec_alu)
    );

    assign mem.MemReq   = mem_req;
    assign mem.AdrSrc   = adr_src;
    assign mem.MemWrite = mem_write;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_I;
        IllegalOp  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = mem.MemReady;
                PCWrite   = mem.MemReady;
                if (mem.MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch/jump target lands in ALUOut for BRANCH/JAL to use.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default: begin
                        IllegalOp = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem.MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem.MemReady) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA    = SRCA_RS1;
                ALUControl = dec_alu;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = dec_alu;
                state_d    = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RS1;
                ALUControl = ALU_SUB;
                PCWrite    = (funct3 == 3'b000) ? Zero :
                             (funct3 == 3'b001) ? ~Zero : 1'b0;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset overrides everything so no enable can fire on the reset edge.
        if (rst) begin
            state_d    = S_FETCH;
            mem_req    = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            ResultSrc  = RES_ALUOUT;
            ALUSrcA    = SRCA_PC;
            ALUSrcB    = SRCB_RS2;
            ALUControl = ALU_ADD;
            ImmSrc     = IMM_I;
            IllegalOp  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

`ifdef MC_PERF_CNT_EN
    logic [DATA_WIDTH-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [DATA_WIDTH-1:0] inst_ret_q, inst_ret_d;
    logic                  retire;

    always_comb begin
        retire = (state_d == S_FETCH) &&
                 (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});
        cycle_cnt_d = cycle_cnt_q + DATA_WIDTH'(1);
        inst_ret_d  = retire ? inst_ret_q + DATA_WIDTH'(1) : inst_ret_q;
        if (rst) begin
            cycle_cnt_d = '0;
            inst_ret_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        cycle_cnt_q <= cycle_cnt_d;
        inst_ret_q  <= inst_ret_d;
    end

    assign CycleCnt = rst ? '0 : cycle_cnt_q;
    assign InstRet  = rst ? '0 : inst_ret_q;
`else
    assign CycleCnt = '0;
    assign InstRet  = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed per-cycle vectors are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        Zero;
    logic        IRWrite, PCWrite, RegWrite, IllegalOp;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [3:0]  ALUControl;
    logic [2:0]  ImmSrc;
    logic [31:0] CycleCnt, InstRet;

    multicycle_ctrl_if mif();

    multicycle_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem(mif), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .IllegalOp(IllegalOp), .CycleCnt(CycleCnt), .InstRet(InstRet)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [19:0] vec;
        logic [31:0] cc;
        logic [31:0] ir;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] exp_cc = 0;
    logic [31:0] exp_ir = 0;

    // {MemReq,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmSrc,IllegalOp}
    function automatic logic [19:0] v(input logic mreq, adr, mw, irw, pcw, rw,
                                      input logic [1:0] res, sa, sb,
                                      input logic [3:0] alu, input logic [2:0] imm,
                                      input logic ill);
        return {mreq, adr, mw, irw, pcw, rw, res, sa, sb, alu, imm, ill};
    endfunction

    logic [19:0] V_FW, V_FR, V_DB, V_DJ, V_ILL, V_AWB, V_MAI, V_MAS, V_MRD, V_MWB, V_MWR, V_JAL, V_LUI;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [19:0] got;
            e   = exp_q.pop_front();
            got = {mif.MemReq, mif.AdrSrc, mif.MemWrite, IRWrite, PCWrite, RegWrite,
                   ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, IllegalOp};
            n_tests++;
            if (got !== e.vec) begin
                n_fail++;
                $display("FAIL %s outputs: got %b want %b", e.nm, got, e.vec);
            end
            n_tests++;
            if (CycleCnt !== e.cc) begin
                n_fail++;
                $display("FAIL %s CycleCnt: got %0d want %0d", e.nm, CycleCnt, e.cc);
            end
            n_tests++;
            if (InstRet !== e.ir) begin
                n_fail++;
                $display("FAIL %s InstRet: got %0d want %0d", e.nm, InstRet, e.ir);
            end
        end
    end

    task automatic step(input string nm, input logic r, input logic [6:0] o,
                        input logic [2:0] f3, input logic [6:0] f7, input logic z,
                        input logic rdy, input logic [19:0] e, input bit ret);
        exp_t x;
        rst = r; op = o; funct3 = f3; funct7 = f7; Zero = z; mif.MemReady = rdy;
        x.nm  = nm;
        x.vec = e;
`ifdef MC_PERF_CNT_EN
        x.cc = r ? 32'd0 : exp_cc;
        x.ir = r ? 32'd0 : exp_ir;
        exp_cc = r ? 32'd0 : exp_cc + 32'd1;
        exp_ir = r ? 32'd0 : exp_ir + (ret ? 32'd1 : 32'd0);
`else
        x.cc = 32'd0;
        x.ir = 32'd0;
`endif
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] v_exr(input logic [3:0] a);
        return v(0,0,0,0,0,0,2'b00,2'b10,2'b00,a,3'b000,0);
    endfunction
    function automatic logic [19:0] v_exi(input logic [3:0] a);
        return v(0,0,0,0,0,0,2'b00,2'b10,2'b01,a,3'b000,0);
    endfunction
    function automatic logic [19:0] v_br(input logic pcw);
        return v(0,0,0,0,pcw,0,2'b00,2'b10,2'b00,4'b0001,3'b000,0);
    endfunction

    task automatic alu_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [3:0] alu);
        step({nm, ".fetch"},  0, o, f3, f7, 0, 1, V_FR, 0);
        step({nm, ".decode"}, 0, o, f3, f7, 0, 0, V_DB, 0);
        step({nm, ".exec"},   0, o, f3, f7, 0, 0, (o == 7'b0110011) ? v_exr(alu) : v_exi(alu), 0);
        step({nm, ".wb"},     0, o, f3, f7, 0, 0, V_AWB, 1);
    endtask

    task automatic branch(input string nm, input logic [2:0] f3, input logic z, input logic pcw);
        step({nm, ".fetch"},  0, 7'b1100011, f3, 0, z, 1, V_FR, 0);
        step({nm, ".decode"}, 0, 7'b1100011, f3, 0, z, 0, V_DB, 0);
        step({nm, ".branch"}, 0, 7'b1100011, f3, 0, z, 0, v_br(pcw), 1);
    endtask

    initial begin
        V_FW  = v(1,0,0,0,0,0,2'b10,2'b00,2'b10,4'b0000,3'b000,0);
        V_FR  = v(1,0,0,1,1,0,2'b10,2'b00,2'b10,4'b0000,3'b000,0);
        V_DB  = v(0,0,0,0,0,0,2'b00,2'b01,2'b01,4'b0000,3'b010,0);
        V_DJ  = v(0,0,0,0,0,0,2'b00,2'b01,2'b01,4'b0000,3'b100,0);
        V_ILL = v(0,0,0,0,0,0,2'b00,2'b01,2'b01,4'b0000,3'b010,1);
        V_AWB = v(0,0,0,0,0,1,2'b00,2'b00,2'b00,4'b0000,3'b000,0);
        V_MAI = v(0,0,0,0,0,0,2'b00,2'b10,2'b01,4'b0000,3'b000,0);
        V_MAS = v(0,0,0,0,0,0,2'b00,2'b10,2'b01,4'b0000,3'b001,0);
        V_MRD = v(1,1,0,0,0,0,2'b00,2'b00,2'b00,4'b0000,3'b000,0);
        V_MWB = v(0,0,0,0,0,1,2'b01,2'b00,2'b00,4'b0000,3'b000,0);
        V_MWR = v(1,1,1,0,0,0,2'b00,2'b00,2'b00,4'b0000,3'b000,0);
        V_JAL = v(0,0,0,0,1,0,2'b00,2'b01,2'b10,4'b0000,3'b000,0);
        V_LUI = v(0,0,0,0,0,0,2'b00,2'b11,2'b01,4'b0000,3'b011,0);
        rst = 1; op = 0; funct3 = 0; funct7 = 0; Zero = 0; mif.MemReady = 1;
        @(posedge clk);
        #1;

        step("reset0", 1, 7'b0110011, 0, 0, 1, 1, 20'd0, 0);
        step("reset1", 1, 7'b0110011, 0, 0, 1, 1, 20'd0, 0);

        alu_instr("add",   7'b0110011, 3'b000, 7'b0000000, 4'b0000);
        alu_instr("sub",   7'b0110011, 3'b000, 7'b0100000, 4'b0001);
        alu_instr("sra",   7'b0110011, 3'b101, 7'b0100000, 4'b0111);
        alu_instr("srl",   7'b0110011, 3'b101, 7'b0000000, 4'b0110);
        alu_instr("and",   7'b0110011, 3'b111, 7'b0000000, 4'b0010);
        alu_instr("sltu",  7'b0110011, 3'b011, 7'b0000000, 4'b1001);
        alu_instr("xor",   7'b0110011, 3'b100, 7'b0000000, 4'b0100);
        alu_instr("sll",   7'b0110011, 3'b001, 7'b0000000, 4'b0101);
        alu_instr("srai",  7'b0010011, 3'b101, 7'b0100000, 4'b0111);
        alu_instr("addi7", 7'b0010011, 3'b000, 7'b0100000, 4'b0000);
        alu_instr("slti",  7'b0010011, 3'b010, 7'b0000000, 4'b1000);
        alu_instr("ori",   7'b0010011, 3'b110, 7'b0000000, 4'b0011);

        // load: one fetch wait, three read waits, MemReady ignored in DECODE/MEMADR
        step("lw.fwait",  0, 7'b0000011, 3'b010, 0, 0, 0, V_FW, 0);
        step("lw.fetch",  0, 7'b0000011, 3'b010, 0, 0, 1, V_FR, 0);
        step("lw.decode", 0, 7'b0000011, 3'b010, 0, 0, 1, V_DB, 0);
        step("lw.memadr", 0, 7'b0000011, 3'b010, 0, 0, 1, V_MAI, 0);
        step("lw.rwait0", 0, 7'b0000011, 3'b010, 0, 0, 0, V_MRD, 0);
        step("lw.rwait1", 0, 7'b0000011, 3'b010, 0, 0, 0, V_MRD, 0);
        step("lw.rwait2", 0, 7'b0000011, 3'b010, 0, 0, 0, V_MRD, 0);
        step("lw.rdone",  0, 7'b0000011, 3'b010, 0, 0, 1, V_MRD, 0);
        step("lw.memwb",  0, 7'b0000011, 3'b010, 0, 0, 0, V_MWB, 1);

        step("sw.fetch",  0, 7'b0100011, 3'b010, 0, 0, 1, V_FR, 0);
        step("sw.decode", 0, 7'b0100011, 3'b010, 0, 0, 0, V_DB, 0);
        step("sw.memadr", 0, 7'b0100011, 3'b010, 0, 0, 0, V_MAS, 0);
        step("sw.wwait0", 0, 7'b0100011, 3'b010, 0, 0, 0, V_MWR, 0);
        step("sw.wwait1", 0, 7'b0100011, 3'b010, 0, 0, 0, V_MWR, 0);
        step("sw.wdone",  0, 7'b0100011, 3'b010, 0, 0, 1, V_MWR, 1);

        branch("beq.z1", 3'b000, 1, 1);
        branch("beq.z0", 3'b000, 0, 0);
        branch("bne.z1", 3'b001, 1, 0);
        branch("bne.z0", 3'b001, 0, 1);
        branch("blt.z1", 3'b100, 1, 0);
        branch("blt.z0", 3'b100, 0, 0);

        step("jal.fetch",  0, 7'b1101111, 0, 0, 0, 1, V_FR, 0);
        step("jal.decode", 0, 7'b1101111, 0, 0, 0, 0, V_DJ, 0);
        step("jal.jal",    0, 7'b1101111, 0, 0, 0, 0, V_JAL, 0);
        step("jal.wb",     0, 7'b1101111, 0, 0, 0, 0, V_AWB, 1);

        step("lui.fetch",  0, 7'b0110111, 0, 0, 0, 1, V_FR, 0);
        step("lui.decode", 0, 7'b0110111, 0, 0, 0, 0, V_DB, 0);
        step("lui.lui",    0, 7'b0110111, 0, 0, 0, 0, V_LUI, 0);
        step("lui.wb",     0, 7'b0110111, 0, 0, 0, 0, V_AWB, 1);

        step("ill.fetch",  0, 7'b0000000, 0, 0, 0, 1, V_FR, 0);
        step("ill.decode", 0, 7'b0000000, 0, 0, 0, 0, V_ILL, 0);
        step("ill.refetch",0, 7'b0000000, 0, 0, 0, 0, V_FW, 0);

        step("rstmid.fetch",  0, 7'b0000011, 3'b010, 0, 0, 1, V_FR, 0);
        step("rstmid.decode", 0, 7'b0000011, 3'b010, 0, 0, 0, V_DB, 0);
        step("rstmid.memadr", 0, 7'b0000011, 3'b010, 0, 0, 0, V_MAI, 0);
        step("rstmid.rwait",  0, 7'b0000011, 3'b010, 0, 0, 0, V_MRD, 0);
        step("rstmid.rst",    1, 7'b0000011, 3'b010, 0, 0, 0, 20'd0, 0);
        step("rstmid.fetch2", 0, 7'b0000011, 3'b010, 0, 0, 0, V_FW, 0);
        step("post.fetch",    0, 7'b0110011, 3'b000, 0, 0, 1, V_FR, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I datapath: one shared memory port, one ALU, with IR, OldPC, Data and ALUOut registers.
- Sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.
- Issues the datapath mux selects, register enables and the memory request.
- Stalls on a ready handshake from the memory port.

Parameters:
- DATA_WIDTH, 32, datapath width; also the width of the perf counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory port completes the current access this cycle.
- MemReq  out  1  memory access request.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  store enable.
- IRWrite  out  1  latch IR and OldPC.
- PCWrite  out  1  PC update enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = constant 4.
- ALUControl  out  4  ALU operation.
- ImmSrc  out  3  immediate type: I = 000, S = 001, B = 010, U = 011, J = 100.
- IllegalOp  out  1  one-cycle pulse on an unsupported opcode.
- CycleCnt  out  DATA_WIDTH  cycle counter (optional feature).
- InstRet  out  DATA_WIDTH  retired-instruction counter (optional feature).

Behaviour:
- Reset and defaults:
  - Clock is clk; reset rst is synchronous and active-high.
  - While rst=1, every output is 0; state becomes FETCH at the edge.
  - Unlisted outputs are 0 in every state.
  - Outputs are decoded from state; only the signals marked "gated" below depend on inputs.
- ALUControl encodings:
  - add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001.
- FETCH:
  - MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite=PCWrite=MemReady (gated).
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add; ImmSrc=J if op is jal, else B. This computes the branch/jump target into ALUOut.
  - Next state: load/store -> MEMADR; R-type -> EXECR; I-ALU -> EXECI; branch -> BRANCH; jal -> JAL; lui -> LUI.
  - Any other op -> FETCH with IllegalOp=1 for this cycle; PC has already advanced by 4.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, add; ImmSrc=S for stores, I for loads.
  - Next state: MEMREAD (load) or MEMWRITE (store).
- MEMREAD:
  - MemReq=1, AdrSrc=1, held stable while MemReady=0; go to MEMWB when MemReady=1.
- MEMWB:
  - ResultSrc=01, RegWrite=1; next FETCH.
- MEMWRITE:
  - MemReq=1, AdrSrc=1, MemWrite=1, held until MemReady=1; next FETCH.
- EXECR:
  - ALUSrcA=10, ALUSrcB=00; next ALUWB.
  - ALUControl by funct3 decode; sub and sra only when funct7=0100000.
- EXECI:
  - ALUSrcA=10, ALUSrcB=01, ImmSrc=I; next ALUWB.
  - Same funct3 decode as EXECR, except funct3=000 is always add; srai when funct7=0100000.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00.
  - PCWrite (gated): Zero for beq (000), ~Zero for bne (001), 0 for all other funct3.
  - Next FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1; next ALUWB.
- LUI:
  - ALUSrcA=11, ALUSrcB=01, ImmSrc=U, add; next ALUWB.
- ALUWB:
  - ResultSrc=00, RegWrite=1; next FETCH.
- Handshake rules:
  - MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
  - No wait-state limit.
- Reset mid-operation:
  - rst=1 in any state, including memory wait states, returns the FSM to FETCH next edge.
  - No write-enable is asserted during the reset cycle.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- Defined:
  - CycleCnt increments every cycle with rst=0.
  - InstRet increments on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Illegal-op transitions do not count.
  - Both counters wrap at 2^DATA_WIDTH and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Package mc_ctrl_pkg holds:
  - opcode constants;
  - state enum;
  - ALUControl encodings;
  - ImmSrc, ResultSrc and ALUSrcA/B select constants.
- One combinational sub-module, alu_decoder: (funct3, funct7, is_rtype) -> ALUControl.
- The FSM and output decode stay in multicycle_ctrl.

Test Plan:
- Reset, then add (op=0110011, f3=000, f7=0), MemReady=1 -> states FETCH, DECODE, EXECR, ALUWB; ALUControl=0000 in EXECR; RegWrite only in cycle 4; next FETCH in cycle 5.
- R sub (f7=0100000) -> 0001; R sra (f3=101, f7=0100000) -> 0111; I srai (op=0010011, same funct) -> 0111; I f3=000 with f7=0100000 -> 0000.
- Load, MemReady held 0 for 3 cycles in MEMREAD -> MemReq=AdrSrc=1 for 4 cycles; RegWrite=1 only in MEMWB with ResultSrc=01; 8 cycles total.
- Store (op=0100011) with 2 wait cycles -> ImmSrc=001 in MEMADR; MemWrite held 3 cycles; RegWrite never asserted.
- beq: Zero=1 -> PCWrite=1 in BRANCH; Zero=0 -> 0. bne inverts this. blt (f3=100) -> 0 regardless of Zero.
- Illegal op 0000000 -> IllegalOp pulses in DECODE, then FETCH. rst during a MEMREAD wait -> all outputs 0 that cycle, FETCH next. With MC_PERF_CNT_EN, InstRet unchanged by either case.
